// File: rtl/msg_tx_scheduler_pkg.sv
// Shared definitions for the message transmit scheduler: default message
// width, FSM state encoding and a constant-evaluable clog2 helper.
package msg_tx_scheduler_pkg;

   localparam int MSG_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Ceiling log2; returns 0 for values of 1 or less.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/msg_tx_scheduler_rr_pick.sv
// Combinational round-robin finder: returns the first set candidate bit
// searching upward from ptr and wrapping at N (N need not be a power of 2).
module rr_pick
   import msg_tx_scheduler_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = clog2(N)
) (
   input  logic [N-1:0]    cand,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] sel,
   output logic            any
);

   int idx;

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any && cand[idx]) begin
            any = 1'b1;
            sel = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Round-robin scheduler sharing one serial message transmitter among N
// requesters. Each requester owns a one-entry slot; one pending, enabled
// slot at a time is sent, then the line is held for frame time plus gap.
module msg_tx_scheduler
   import msg_tx_scheduler_pkg::*;
#(
   parameter int N            = 4,
   parameter int MSG_W        = msg_tx_scheduler_pkg::MSG_W,
   parameter int FRAME_CYCLES = 100,
   parameter int GAP_CYCLES   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req_valid,
   input  logic [N*MSG_W-1:0]    req_msg,
   output logic [N-1:0]          req_ready,
   input  logic [N-1:0]          en,
   output logic                  send,
   output logic [MSG_W-1:0]      message,
   output logic                  busy,
   output logic [clog2(N)-1:0]   grant_id,
   output logic [N-1:0]          done,
   output state_t                dbg_state
);

   localparam int ID_W      = clog2(N);
   localparam int TIMER_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
   localparam int TIMER_W   = clog2(TIMER_MAX + 1);
   localparam logic [TIMER_W-1:0] FRAME_LOAD = TIMER_W'(FRAME_CYCLES - 2);
   localparam logic [TIMER_W-1:0] GAP_LOAD   =
      (GAP_CYCLES > 0) ? TIMER_W'(GAP_CYCLES - 1) : '0;

   state_t             state, state_nxt;
   logic [N-1:0]       pending;
   logic [MSG_W-1:0]   slot [N];
   logic [ID_W-1:0]    ptr;
   logic [TIMER_W-1:0] timer;
   logic               timer_zero;
   logic [N-1:0]       cand;
   logic [ID_W-1:0]    sel;
   logic               any;

   // Handshake: requester i transfers req_msg[i] on any rising edge where
   // req_valid[i] and req_ready[i] are both high. req_ready[i] comes only from
   // the pending register, so it never depends on req_valid in the same cycle.
   assign req_ready  = ~pending;
   assign cand       = pending & en;
   assign timer_zero = (timer == '0);

   rr_pick #(.N(N), .ID_W(ID_W)) u_rr_pick (
      .cand (cand),
      .ptr  (ptr),
      .sel  (sel),
      .any  (any)
   );

   // Slot capture on accept; the granted slot is released in the SEND cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
         for (int i = 0; i < N; i++) slot[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (state == ST_SEND && grant_id == ID_W'(i)) begin
               pending[i] <= 1'b0;
            end else if (req_valid[i] && !pending[i]) begin
               pending[i] <= 1'b1;
               slot[i]    <= req_msg[i*MSG_W +: MSG_W];
            end
         end
      end
   end

   // Grant latch: message and grant_id stay stable from SEND until next grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_id <= '0;
         message  <= '0;
      end else if (state == ST_IDLE && any) begin
         grant_id <= sel;
         message  <= slot[sel];
      end
   end

   // Completion pulse and round-robin pointer advance at end of frame time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done <= '0;
         ptr  <= '0;
      end else begin
         done <= '0;
         if (state == ST_WAIT && timer_zero) begin
            done[grant_id] <= 1'b1;
            ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
         end
      end
   end

   // Frame and gap down-counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
      end else begin
         case (state)
            ST_SEND: timer <= FRAME_LOAD;
            ST_WAIT: timer <= timer_zero ? GAP_LOAD : timer - 1'b1;
            ST_GAP:  timer <= timer_zero ? '0 : timer - 1'b1;
            default: timer <= timer;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any) state_nxt = ST_SEND;
         ST_SEND: state_nxt = ST_WAIT;
         ST_WAIT: if (timer_zero) state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:  if (timer_zero) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from state.
   always_comb begin
      send      = (state == ST_SEND);
      busy      = (state != ST_IDLE);
      dbg_state = state;
   end

endmodule

// File: doc/msg_tx_scheduler.md
# msg_tx_scheduler

Round-robin scheduler that shares the 5-bit serial message transmitter among N independent requesters. Each requester hands over a 5-bit message through a valid/ready handshake into a one-entry holding slot. The scheduler picks one pending slot at a time and drives the transmitter's `send`/`message` inputs. It then holds off for a fixed frame time plus an inter-frame gap, and reports completion to the granted requester. It sits directly in front of the transmitter, which exposes no busy flag of its own.

## Interface
- `N`, 4: number of requesters, 2..8.
- `MSG_W`, 5: message width; must match the transmitter.
- `FRAME_CYCLES`, 100: clock cycles one frame occupies on the serial line, measured from the `send` cycle. Must be ≥ 2.
- `GAP_CYCLES`, 10: idle cycles forced between frames. 0 is legal.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_valid`  in  N  requester i offers a message.
- `req_msg`  in  N*MSG_W  message of requester i, at bits [i*MSG_W +: MSG_W].
- `req_ready`  out  N  slot i empty; accept occurs on a cycle where valid and ready are both high.
- `en`  in  N  grant-enable mask. A masked requester can still fill its slot but is never granted.
- `send`  out  1  one-cycle start pulse to the transmitter.
- `message`  out  MSG_W  message to the transmitter.
- `busy`  out  1  high in SEND, WAIT and GAP.
- `grant_id`  out  clog2(N)  index of the requester currently being served.
- `done`  out  N  one-cycle pulse to requester i when its frame time expires.

## Operation
- Per requester: `pending[i]` flag and `slot[i]` register. `req_ready[i]` = ~`pending[i]`, driven from the register only.
- An accept sets `pending[i]` and captures `req_msg[i]`.
- Round-robin pointer `ptr`: next candidate index, reset 0.
- States: IDLE, SEND, WAIT, GAP. Reset state is IDLE.
- IDLE:
  - `cand` = `pending` & `en`.
  - If `cand` is nonzero, `sel` = first set bit searching from `ptr` upward, wrapping at N.
  - Latch `grant_id` <= `sel` and `message` <= `slot[sel]`, then go to SEND.
- SEND:
  - `send` = 1 for this one cycle.
  - Clear `pending[grant_id]`.
  - Load `timer` <= FRAME_CYCLES-2, then go to WAIT.
- WAIT:
  - Decrement `timer`.
  - When `timer` == 0: pulse `done[grant_id]` and set `ptr` <= (`grant_id`+1) mod N.
  - Then go to GAP with `timer` <= GAP_CYCLES-1, or to IDLE if GAP_CYCLES == 0.
- GAP: decrement `timer`; at 0, go to IDLE.
- `message` and `grant_id` hold their values from SEND until the next grant. The transmitter samples `message` while idle, so the value must be stable in the SEND cycle.
- Arithmetic:
  - `timer` width is clog2(max(FRAME_CYCLES, GAP_CYCLES)+1).
  - `ptr` wraps modulo N. N need not be a power of two.
- Boundary conditions:
  - Same requester re-offers during its own frame: the slot is free from the cycle after SEND. The new message is accepted and held; the frame in flight is unaffected.
  - `en[i]` deasserted while i is pending: i is skipped and its message is kept. Deasserting during WAIT does not abort the current frame.
  - All pending but all masked: stay in IDLE with `send` = 0.
  - Reset mid-frame: everything clears immediately. The transmitter is reset by the same `rst` network.

## Timing
- Reset values:
  - `req_ready` all 1.
  - `send` 0, `message` 0, `busy` 0, `grant_id` 0, `done` 0.
  - `pending` 0, `ptr` 0.
- Latency: accept at cycle t → earliest `send` at t+2 (t+1 pending set, IDLE grants; t+2 SEND).
- `done` pulse is FRAME_CYCLES cycles after `send`.
- Next `send` is no earlier than FRAME_CYCLES + GAP_CYCLES + 1 cycles after the previous one (one IDLE cycle included).
- All outputs are registered or decoded directly from state. There is no combinational path from `req_valid` to `req_ready`.

## Structure
- Shared package holds:
  - `MSG_W`.
  - State encoding constants (IDLE/SEND/WAIT/GAP).
  - A clog2 helper function.
- One sub-module, `rr_pick`: a combinational round-robin finder. Inputs `cand[N]` and `ptr`; outputs `sel` and `any`.
- Slots, FSM and timer live in the top level.

## Test plan
- Single request: N=4, FRAME=100, GAP=10. Requester 2 offers 5'b10110 → `send` 2 cycles later with `message` = 10110 and `grant_id` = 2; `done[2]` exactly 100 cycles after `send`; `busy` drops 10 cycles after that.
- Fairness: all four requesters pending from reset → grant order 0, 1, 2, 3. Requester 0 refills immediately → order continues 0, 1, 2, 3, with no repeat of 0 before 3.
- Masking: 1 and 3 pending, `en` = 4'b1101 → only 3 is served; 1 stays pending with `req_ready[1]` = 0. Setting `en[1]` then grants 1.
- Back-to-back refill: requester 0 re-offers 5'b00001 in the cycle after its SEND → accepted at once. It is sent only after `done[0]` + gap + IDLE, and the frame in flight keeps its old `message`.
- GAP_CYCLES=0: two pending → `send` pulses are exactly FRAME_CYCLES+1 cycles apart.
- Reset mid-WAIT: assert `rst`=0 at cycle 40 of a frame → `send`, `busy` and `done` are 0 and `req_ready` = all 1 immediately. After release, no `done` pulse appears for the aborted frame.
